// File: rtl/hazard_sched_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sched_ctrl_pkg
//  Description : Shared types and constants for the pipeline sequencing
//                controller (state encoding, register index, NOP word).
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_sched_ctrl_pkg;

    // Controller states; RUN must encode as zero so reset lands there.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_t;

    // Architectural register index of the SIMPLE core.
    typedef logic [2:0] regIdx_t;

    // Instruction word the p2 latch loads when p2_bubble is asserted.
    localparam logic [15:0] c_NOP_INSTR = 16'h0000;

    // Width of the load-use stall counter (LOAD_LAT is at most 3).
    localparam int LU_W = 2;

endpackage : hazard_sched_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_sched_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sched_cnt
//  Description : Generic up-counter with clear, load, enable and pause that
//                saturates at all-ones. Clear beats load beats counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sched_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ldVal,
    input  logic         en,
    input  logic         pause,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] c_MAX = '1;

    logic [W-1:0] r_cnt;

    // Count register: clear, load, or saturating increment when not paused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (ld) begin
            r_cnt <= ldVal;
        end else if (en && !pause && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule : hazard_sched_cnt
`default_nettype wire

// File: rtl/hazard_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sched_ctrl
//  Description : Pipeline sequencing controller. Drives PC / latch enables,
//                bubbles and flushes for load-use stalls, memory wait states
//                with timeout, taken-branch flushes and halt/restart.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sched_ctrl
    import hazard_sched_ctrl_pkg::*;
#(
    parameter int LOAD_LAT    = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int TO_W        = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  regIdx_t          p1_RegRs,
    input  regIdx_t          p1_RegRt,
    input  logic             p1_UseRs,
    input  logic             p1_UseRt,
    input  regIdx_t          p2_RegRd,
    input  logic             p2_MemRead,
    input  logic             p3_BrTaken,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             halt_req,
    input  logic             restart,
    input  logic             stat_clr,
    output logic             pc_we,
    output logic             p1_we,
    output logic             p2_bubble,
    output logic             p1_flush,
    output logic             p2_flush,
    output logic             p3_we,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    // The lu counter counts stall cycles already spent in LU_STALL; the
    // RUN-state bubble is the first one, so LU_STALL exits at LOAD_LAT-2.
    localparam logic [LU_W-1:0] c_LU_LAST = LU_W'(LOAD_LAT - 2);
    // Timeout counter enters MEM_WAIT at 1; the cycle it reads
    // MEM_TIMEOUT-1 without an ack is the cycle it would reach MEM_TIMEOUT.
    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [TO_W-1:0] c_TO_ONE  = TO_W'(1);

    state_t          r_state;
    state_t          w_nxtState;
    logic            r_memErr;
    logic            w_lu;
    logic            w_memWait;
    logic            w_luClr;
    logic            w_luEn;
    logic            w_luPause;
    logic            w_toLd;
    logic            w_toEn;
    logic            w_errSet;
    logic            w_stallInc;
    logic [LU_W-1:0] w_luCnt;
    logic [TO_W-1:0] w_toCnt;

    assign w_lu = p2_MemRead &
                  ((p1_UseRs & (p2_RegRd == p1_RegRs)) |
                   (p1_UseRt & (p2_RegRd == p1_RegRt)));
    assign w_memWait = mem_req & ~mem_ack;

    // State register and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_memErr <= 1'b0;
        end else begin
            r_state <= w_nxtState;
            if (w_errSet) begin
                r_memErr <= 1'b1;
            end
        end
    end

    // Next-state, counter controls and pipeline enables.
    always_comb begin
        w_nxtState = r_state;
        pc_we      = 1'b0;
        p1_we      = 1'b0;
        p2_bubble  = 1'b0;
        p1_flush   = 1'b0;
        p2_flush   = 1'b0;
        p3_we      = 1'b0;
        halted     = 1'b0;
        w_luClr    = 1'b0;
        w_luEn     = 1'b0;
        w_luPause  = 1'b0;
        w_toLd     = 1'b0;
        w_toEn     = 1'b0;
        w_errSet   = 1'b0;

        case (r_state)
            RUN: begin
                if (halt_req) begin
                    w_nxtState = HALT;
                end else if (w_memWait) begin
                    w_nxtState = MEM_WAIT;
                    w_toLd     = 1'b1;
                end else if (p3_BrTaken) begin
                    // Branch squashes the hazard instruction, so no stall.
                    pc_we    = 1'b1;
                    p1_we    = 1'b1;
                    p3_we    = 1'b1;
                    p1_flush = 1'b1;
                    p2_flush = 1'b1;
                end else if (w_lu) begin
                    p2_bubble = 1'b1;
                    p3_we     = 1'b1;
                    if (LOAD_LAT > 1) begin
                        w_nxtState = LU_STALL;
                        w_luClr    = 1'b1;
                    end
                end else begin
                    pc_we = 1'b1;
                    p1_we = 1'b1;
                    p3_we = 1'b1;
                end
            end
            LU_STALL: begin
                if (halt_req) begin
                    w_nxtState = HALT;
                end else if (w_memWait) begin
                    w_luPause = 1'b1;
                end else begin
                    p2_bubble = 1'b1;
                    p3_we     = 1'b1;
                    if (w_luCnt == c_LU_LAST) begin
                        w_nxtState = RUN;
                    end else begin
                        w_luEn = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    w_nxtState = RUN;
                end else if (w_toCnt >= c_TO_LAST) begin
                    w_errSet   = 1'b1;
                    w_nxtState = HALT;
                end else begin
                    w_toEn = 1'b1;
                end
            end
            HALT: begin
                halted = 1'b1;
                if (restart && !halt_req) begin
                    w_nxtState = RUN;
                end
            end
            default: begin
                w_nxtState = RUN;
            end
        endcase

        // A flushed p2 must never also receive a bubble.
        if (p2_flush) begin
            p2_bubble = 1'b0;
        end

        // Everything quiet while reset is held.
        if (!rst_n) begin
            w_nxtState = RUN;
            pc_we      = 1'b0;
            p1_we      = 1'b0;
            p2_bubble  = 1'b0;
            p1_flush   = 1'b0;
            p2_flush   = 1'b0;
            p3_we      = 1'b0;
            halted     = 1'b0;
            w_errSet   = 1'b0;
        end
    end

    assign mem_err    = r_memErr;
    assign w_stallInc = rst_n & (r_state != HALT) & ~pc_we;

    hazard_sched_cnt #(.W(LU_W)) u_luCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_luClr),
        .ld    (1'b0),
        .ldVal ({LU_W{1'b0}}),
        .en    (w_luEn),
        .pause (w_luPause),
        .cnt   (w_luCnt)
    );

    hazard_sched_cnt #(.W(TO_W)) u_toCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .ld    (w_toLd),
        .ldVal (c_TO_ONE),
        .en    (w_toEn),
        .pause (1'b0),
        .cnt   (w_toCnt)
    );

    hazard_sched_cnt #(.W(CNT_W)) u_stallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (stat_clr),
        .ld    (1'b0),
        .ldVal ({CNT_W{1'b0}}),
        .en    (w_stallInc),
        .pause (1'b0),
        .cnt   (stall_cnt)
    );

endmodule : hazard_sched_ctrl
`default_nettype wire

// File: tb/tb_hazard_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_sched_ctrl
//  Description : Directed self-checking bench. Instance A uses LOAD_LAT=1 and
//                the default timeout; instance B uses LOAD_LAT=3 and
//                MEM_TIMEOUT=4. Both share one set of inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_sched_ctrl;

    // Output vector order: {pc_we,p1_we,p2_bubble,p1_flush,p2_flush,p3_we,halted,mem_err}
    localparam logic [7:0] c_RUN    = 8'b1100_0100;
    localparam logic [7:0] c_BUBBLE = 8'b0010_0100;
    localparam logic [7:0] c_BRANCH = 8'b1101_1100;
    localparam logic [7:0] c_FROZEN = 8'b0000_0000;
    localparam logic [7:0] c_HALTED = 8'b0000_0010;
    localparam logic [7:0] c_HLTERR = 8'b0000_0011;
    localparam logic [7:0] c_RUNERR = 8'b1100_0101;

    logic        clk;
    logic        rst_n;
    logic [2:0]  p1_RegRs, p1_RegRt, p2_RegRd;
    logic        p1_UseRs, p1_UseRt, p2_MemRead, p3_BrTaken;
    logic        mem_req, mem_ack, halt_req, restart, stat_clr;

    logic        aPcWe, aP1We, aBub, aF1, aF2, aP3We, aHalted, aErr;
    logic        bPcWe, bP1We, bBub, bF1, bF2, bP3We, bHalted, bErr;
    logic [15:0] aStall, bStall;
    logic [7:0]  aOut, bOut;

    int nChecks = 0;
    int nErrors = 0;

    assign aOut = {aPcWe, aP1We, aBub, aF1, aF2, aP3We, aHalted, aErr};
    assign bOut = {bPcWe, bP1We, bBub, bF1, bF2, bP3We, bHalted, bErr};

    hazard_sched_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(255), .TO_W(8), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n),
        .p1_RegRs(p1_RegRs), .p1_RegRt(p1_RegRt), .p1_UseRs(p1_UseRs), .p1_UseRt(p1_UseRt),
        .p2_RegRd(p2_RegRd), .p2_MemRead(p2_MemRead), .p3_BrTaken(p3_BrTaken),
        .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .restart(restart),
        .stat_clr(stat_clr),
        .pc_we(aPcWe), .p1_we(aP1We), .p2_bubble(aBub), .p1_flush(aF1), .p2_flush(aF2),
        .p3_we(aP3We), .halted(aHalted), .mem_err(aErr), .stall_cnt(aStall)
    );

    hazard_sched_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(4), .TO_W(8), .CNT_W(16)) dutB (
        .clk(clk), .rst_n(rst_n),
        .p1_RegRs(p1_RegRs), .p1_RegRt(p1_RegRt), .p1_UseRs(p1_UseRs), .p1_UseRt(p1_UseRt),
        .p2_RegRd(p2_RegRd), .p2_MemRead(p2_MemRead), .p3_BrTaken(p3_BrTaken),
        .mem_req(mem_req), .mem_ack(mem_ack), .halt_req(halt_req), .restart(restart),
        .stat_clr(stat_clr),
        .pc_we(bPcWe), .p1_we(bP1We), .p2_bubble(bBub), .p1_flush(bF1), .p2_flush(bF2),
        .p3_we(bP3We), .halted(bHalted), .mem_err(bErr), .stall_cnt(bStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        p1_RegRs = 3'd0; p1_RegRt = 3'd0; p2_RegRd = 3'd0;
        p1_UseRs = 1'b0; p1_UseRt = 1'b0; p2_MemRead = 1'b0; p3_BrTaken = 1'b0;
        mem_req = 1'b0; mem_ack = 1'b0; halt_req = 1'b0; restart = 1'b0; stat_clr = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        clearIn();
        #2;
        chk("rst_outA", {8'h00, aOut}, 16'h0000);
        chk("rst_outB", {8'h00, bOut}, 16'h0000);
        chk("rst_stallA", aStall, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        clearIn();
        cyc();

        // Load-use on Rs, LOAD_LAT=1: a single bubble then RUN.
        doReset();
        p2_MemRead = 1'b1; p2_RegRd = 3'd3; p1_RegRs = 3'd3; p1_UseRs = 1'b1;
        #2 chk("lu1_bubble", {8'h00, aOut}, {8'h00, c_BUBBLE});
        cyc();
        clearIn();
        #2 chk("lu1_run", {8'h00, aOut}, {8'h00, c_RUN});
        chk("lu1_stall", aStall, 16'd1);

        // Load-use on Rt, LOAD_LAT=3: three consecutive bubbles.
        doReset();
        p2_MemRead = 1'b1; p2_RegRd = 3'd3; p1_RegRs = 3'd5; p1_UseRs = 1'b0;
        p1_RegRt = 3'd3; p1_UseRt = 1'b1;
        #2 chk("lu3_b1", {8'h00, bOut}, {8'h00, c_BUBBLE});
        cyc();
        #2 chk("lu3_b2", {8'h00, bOut}, {8'h00, c_BUBBLE});
        cyc();
        #2 chk("lu3_b3", {8'h00, bOut}, {8'h00, c_BUBBLE});
        cyc();
        clearIn();
        #2 chk("lu3_run", {8'h00, bOut}, {8'h00, c_RUN});
        chk("lu3_stall", bStall, 16'd3);
        // Same match but Rt not used: no hazard.
        p2_MemRead = 1'b1; p2_RegRd = 3'd3; p1_RegRt = 3'd3; p1_UseRt = 1'b0;
        #2 chk("lu3_nort", {8'h00, bOut}, {8'h00, c_RUN});
        cyc();
        clearIn();
        #2 chk("lu3_nort_stall", bStall, 16'd3);

        // Taken branch with a simultaneous load-use hazard.
        doReset();
        p2_MemRead = 1'b1; p2_RegRd = 3'd2; p1_RegRs = 3'd2; p1_UseRs = 1'b1; p3_BrTaken = 1'b1;
        #2 chk("br_A", {8'h00, aOut}, {8'h00, c_BRANCH});
        chk("br_B", {8'h00, bOut}, {8'h00, c_BRANCH});
        cyc();
        clearIn();
        #2 chk("br_after_B", {8'h00, bOut}, {8'h00, c_RUN});
        chk("br_stall", aStall, 16'd0);

        // Memory wait: ack in the fifth frozen cycle (A); B times out at 4.
        doReset();
        mem_req = 1'b1;
        #2 chk("mw_c0", {8'h00, aOut}, {8'h00, c_FROZEN});
        cyc();
        #2 chk("mw_c1", {8'h00, aOut}, {8'h00, c_FROZEN});
        cyc();
        cyc();
        #2 chk("to_c3_B", {8'h00, bOut}, {8'h00, c_FROZEN});
        cyc();
        mem_ack = 1'b1;
        #2 chk("mw_c4", {8'h00, aOut}, {8'h00, c_FROZEN});
        chk("to_halt_B", {8'h00, bOut}, {8'h00, c_HLTERR});
        cyc();
        clearIn();
        #2 chk("mw_run", {8'h00, aOut}, {8'h00, c_RUN});
        chk("mw_stall", aStall, 16'd5);
        chk("to_stall_B", bStall, 16'd4);

        // Statistics clear.
        stat_clr = 1'b1;
        cyc();
        stat_clr = 1'b0;
        #2 chk("clr_stall", aStall, 16'd0);

        // Restart while halt_req is still high keeps HALT; A enters HALT.
        restart = 1'b1; halt_req = 1'b1;
        #2 chk("halt_req_A", {8'h00, aOut}, {8'h00, c_FROZEN});
        cyc();
        #2 chk("rst_hold_B", {8'h00, bOut}, {8'h00, c_HLTERR});
        chk("halted_A", {8'h00, aOut}, {8'h00, c_HALTED});
        halt_req = 1'b0;
        cyc();
        restart = 1'b0;
        #2 chk("restart_B", {8'h00, bOut}, {8'h00, c_RUNERR});
        chk("restart_A", {8'h00, aOut}, {8'h00, c_RUN});
        chk("halt_nocount_B", bStall, 16'd0);
        chk("halt_count_A", aStall, 16'd1);

        // Reset clears the sticky error.
        doReset();
        #2 chk("err_cleared_B", {8'h00, bOut}, {8'h00, c_RUN});

        // Async reset in the middle of a LOAD_LAT=3 stall.
        p2_MemRead = 1'b1; p2_RegRd = 3'd4; p1_RegRs = 3'd4; p1_UseRs = 1'b1;
        #2 chk("ar_b1", {8'h00, bOut}, {8'h00, c_BUBBLE});
        cyc();
        #2 chk("ar_b2", {8'h00, bOut}, {8'h00, c_BUBBLE});
        rst_n = 1'b0;
        #1 chk("ar_inrst_B", {8'h00, bOut}, 16'h0000);
        chk("ar_inrst_stall", bStall, 16'd0);
        clearIn();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        #2 chk("ar_run_B", {8'h00, bOut}, {8'h00, c_RUN});

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_hazard_sched_ctrl
`default_nettype wire
